// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 request arbiter.
// An fma16_op_t packs operands and controls in the same order as a requester's x/y/z/ctrl fields.
package fma16_pkg;

  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;
  localparam int FLAGS_W = FLG_NV + 1;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        mul;
    logic        add;
    logic        negp;
    logic        negz;
    logic [1:0]  roundmode;
  } fma16_op_t;

  function automatic fma16_op_t make_op(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z, input logic [5:0] ctrl);
    make_op = {x, y, z, ctrl};
  endfunction

endpackage

// File: rtl/fma16_arb_rr_arbiter.sv
// Round-robin arbiter: the requester after the last granted one has top priority.
// The last_grant pointer moves only when the granted request is actually taken (advance).
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] last_grant;
  logic          found;
  int            j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(last_grant) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  // Resetting to N-1 makes requester 0 the first in line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= IW'(N - 1);
    end else if (advance) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/fma16_arb.sv
// Shares one combinational fma16 datapath among NREQ requesters through a two-stage
// pipeline: S1 drives the datapath operands, S2 captures its result for the consumer.
module fma16_arb
  import fma16_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TAGW = 3,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  input  logic [16*NREQ-1:0]   req_z,
  input  logic [6*NREQ-1:0]    req_ctrl,
  input  logic [TAGW*NREQ-1:0] req_tag,
  output logic [15:0]          fma_x,
  output logic [15:0]          fma_y,
  output logic [15:0]          fma_z,
  output logic                 fma_mul,
  output logic                 fma_add,
  output logic                 fma_negp,
  output logic                 fma_negz,
  output logic [1:0]           fma_roundmode,
  input  logic [15:0]          fma_result,
  input  logic [FLAGS_W-1:0]   fma_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_result,
  output logic [FLAGS_W-1:0]   rsp_flags,
  output logic [IDW-1:0]       rsp_id,
  output logic [TAGW-1:0]      rsp_tag,
  output logic [FLAGS_W-1:0]   acc_flags,
  input  logic                 clr_flags,
  output logic                 busy
);

  logic                s1_valid;
  fma16_op_t           s1_op;
  logic [TAGW-1:0]     s1_tag;
  logic [IDW-1:0]      s1_id;

  logic                s2_valid;
  logic [15:0]         s2_result;
  logic [FLAGS_W-1:0]  s2_flags;
  logic [IDW-1:0]      s2_id;
  logic [TAGW-1:0]     s2_tag;

  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      grant_idx;
  fma16_op_t           sel_op;
  logic [TAGW-1:0]     sel_tag;
  logic                s2_adv;
  logic                s1_free;
  logic                accept;
  logic                rsp_hs;

  assign s2_adv  = s1_valid & (~s2_valid | rsp_ready);
  assign s1_free = ~s1_valid | s2_adv;
  assign rsp_hs  = s2_valid & rsp_ready;

  // Ready is held low while reset is asserted even if a requester is already valid.
  assign req_ready = reset ? '0 : (grant & {NREQ{s1_free}});
  assign accept    = |(req_valid & req_ready);

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_op  = '0;
    sel_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op  = make_op(req_x[16*i +: 16], req_y[16*i +: 16], req_z[16*i +: 16],
                          req_ctrl[6*i +: 6]);
        sel_tag = req_tag[TAGW*i +: TAGW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_tag   <= '0;
      s1_id    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= sel_op;
      s1_tag   <= sel_tag;
      s1_id    <= grant_idx;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
      s2_id     <= '0;
      s2_tag    <= '0;
    end else if (s2_adv) begin
      s2_valid  <= 1'b1;
      s2_result <= fma_result;
      s2_flags  <= fma_flags;
      s2_id     <= s1_id;
      s2_tag    <= s1_tag;
    end else if (rsp_hs) begin
      s2_valid  <= 1'b0;
    end
  end

  // A clear coinciding with a handshake keeps only the flags of that response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_flags <= '0;
    end else if (clr_flags) begin
      acc_flags <= rsp_hs ? s2_flags : '0;
    end else if (rsp_hs) begin
      acc_flags <= acc_flags | s2_flags;
    end
  end

  assign fma_x         = s1_op.x;
  assign fma_y         = s1_op.y;
  assign fma_z         = s1_op.z;
  assign fma_mul       = s1_op.mul;
  assign fma_add       = s1_op.add;
  assign fma_negp      = s1_op.negp;
  assign fma_negz      = s1_op.negz;
  assign fma_roundmode = s1_op.roundmode;

  assign rsp_valid  = s2_valid;
  assign rsp_result = s2_result;
  assign rsp_flags  = s2_flags;
  assign rsp_id     = s2_id;
  assign rsp_tag    = s2_tag;
  assign busy       = s1_valid | s2_valid;

endmodule

// File: tb/tb_fma16_arb.sv
// Directed bench for fma16_arb with four requesters; a table-driven stand-in
// for the fma16 datapath supplies results for the operand sets used here.
module tb_fma16_arb;

  localparam int NREQ = 4;
  localparam int TAGW = 3;
  localparam logic [5:0] MUL = 6'b100000;
  localparam logic [5:0] FMA = 6'b110000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_x, req_y, req_z;
  logic [6*NREQ-1:0]    req_ctrl;
  logic [TAGW*NREQ-1:0] req_tag;
  logic [15:0]          fma_x, fma_y, fma_z;
  logic                 fma_mul, fma_add, fma_negp, fma_negz;
  logic [1:0]           fma_roundmode;
  logic [15:0]          fma_result;
  logic [3:0]           fma_flags;
  logic                 rsp_valid, rsp_ready;
  logic [15:0]          rsp_result;
  logic [3:0]           rsp_flags;
  logic [1:0]           rsp_id;
  logic [TAGW-1:0]      rsp_tag;
  logic [3:0]           acc_flags;
  logic                 clr_flags;
  logic                 busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fma16_arb #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_ctrl(req_ctrl), .req_tag(req_tag),
    .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
    .fma_mul(fma_mul), .fma_add(fma_add), .fma_negp(fma_negp), .fma_negz(fma_negz),
    .fma_roundmode(fma_roundmode), .fma_result(fma_result), .fma_flags(fma_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .acc_flags(acc_flags), .clr_flags(clr_flags), .busy(busy)
  );

  // Half-precision results for the operand sets this bench issues; anything else reads as NaN/NV.
  always_comb begin
    fma_result = 16'h7E00;
    fma_flags  = 4'b1000;
    case ({fma_x, fma_y, fma_z})
      {16'h3C00, 16'h4000, 16'h0000}: begin fma_result = 16'h4000; fma_flags = 4'b0000; end
      {16'h3C00, 16'h3C00, 16'h3C00}: begin fma_result = 16'h4000; fma_flags = 4'b0000; end
      {16'h7BFF, 16'h7BFF, 16'h0000}: begin fma_result = 16'h7C00; fma_flags = 4'b0101; end
      {16'h3C00, 16'h3C00, 16'h0000}: begin fma_result = 16'h3C00; fma_flags = 4'b0000; end
      {16'h3C00, 16'h3C00, 16'h0C00}: begin fma_result = 16'h3C00; fma_flags = 4'b0001; end
      {16'h4000, 16'h4000, 16'h0000}: begin fma_result = 16'h4400; fma_flags = 4'b0000; end
      {16'h4200, 16'h4000, 16'h0000}: begin fma_result = 16'h4600; fma_flags = 4'b0000; end
      default: begin fma_result = 16'h7E00; fma_flags = 4'b1000; end
    endcase
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z, input logic [5:0] ctrl, input logic [TAGW-1:0] tag);
    req_x[16*i +: 16]      = x;
    req_y[16*i +: 16]      = y;
    req_z[16*i +: 16]      = z;
    req_ctrl[6*i +: 6]     = ctrl;
    req_tag[TAGW*i +: TAGW] = tag;
  endtask

  // Issues one op from an idle pipeline and waits (bounded) until its response is presented.
  task automatic send_op(input int i, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z, input logic [5:0] ctrl, input logic [TAGW-1:0] tag,
                         output bit seen);
    set_op(i, x, y, z, ctrl, tag);
    req_valid = NREQ'(1 << i);
    tick();
    req_valid = '0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_z = '0;
    req_ctrl = '0; req_tag = '0; rsp_ready = 1'b0; clr_flags = 1'b0;
    repeat (2) tick();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (acc_flags !== 4'b0) begin n_err++; $display("[TB] FAIL reset_acc got %b want 0000", acc_flags); end
    n_vec++; if (fma_x !== 16'h0) begin n_err++; $display("[TB] FAIL reset_fma_x got %h want 0000", fma_x); end
    n_vec++; if (rsp_result !== 16'h0) begin n_err++; $display("[TB] FAIL reset_rsp_result got %h want 0000", rsp_result); end
    req_valid = 4'b0001;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("[TB] FAIL reset_req_ready got %b want 0000", req_ready); end
    req_valid = '0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_op;
    set_op(0, 16'h3C00, 16'h4000, 16'h0000, MUL, 3'd5);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("[TB] FAIL single_ready got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL single_early_valid got %b want 0", rsp_valid); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL single_busy got %b want 1", busy); end
    n_vec++; if (fma_x !== 16'h3C00 || fma_y !== 16'h4000 || fma_mul !== 1'b1 || fma_add !== 1'b0)
      begin n_err++; $display("[TB] FAIL single_fma_ops got x=%h y=%h mul=%b add=%b want 3c00 4000 1 0", fma_x, fma_y, fma_mul, fma_add); end
    tick();
    #1;
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("[TB] FAIL single_rsp_valid got %b want 1", rsp_valid); end
    n_vec++; if (rsp_result !== 16'h4000) begin n_err++; $display("[TB] FAIL single_result got %h want 4000", rsp_result); end
    n_vec++; if (rsp_flags !== 4'b0000) begin n_err++; $display("[TB] FAIL single_flags got %b want 0000", rsp_flags); end
    n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("[TB] FAIL single_id got %0d want 0", rsp_id); end
    n_vec++; if (rsp_tag !== 3'd5) begin n_err++; $display("[TB] FAIL single_tag got %0d want 5", rsp_tag); end
    tick();
    #1;
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("[TB] FAIL single_drain got valid=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_contention;
    logic [3:0] exp_ready;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_op(0, 16'h3C00, 16'h3C00, 16'h3C00, FMA, 3'd1);
    set_op(1, 16'h3C00, 16'h3C00, 16'h3C00, FMA, 3'd2);
    req_valid = 4'b0011; rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      exp_ready = (c >= 8) ? 4'b0000 : ((c % 2) != 0 ? 4'b0010 : 4'b0001);
      n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("[TB] FAIL contention_ready[%0d] got %b want %b", c, req_ready, exp_ready); end
      if (c >= 2) begin
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'h4000 || rsp_id !== 2'(c % 2) || rsp_tag !== 3'((c % 2) != 0 ? 2 : 1)) begin
          n_err++;
          $display("[TB] FAIL contention_rsp[%0d] got v=%b r=%h id=%0d tag=%0d want 1 4000 %0d %0d",
                   c, rsp_valid, rsp_result, rsp_id, rsp_tag, c % 2, (c % 2) != 0 ? 2 : 1);
        end
      end
      tick();
    end
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL contention_drain got busy=%b want 0", busy); end
  endtask

  task automatic test_backpressure;
    set_op(0, 16'h4000, 16'h4000, 16'h0000, MUL, 3'd3);
    req_valid = 4'b0001; rsp_ready = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("[TB] FAIL bp_ready_a got %b want 0001", req_ready); end
    tick();
    set_op(0, 16'h4200, 16'h4000, 16'h0000, MUL, 3'd4);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("[TB] FAIL bp_ready_b got %b want 0001", req_ready); end
    tick();
    set_op(0, 16'h3C00, 16'h3C00, 16'h0000, MUL, 3'd6);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_result !== 16'h4400 || rsp_tag !== 3'd3 || fma_x !== 16'h4200 || req_ready !== 4'b0000) begin
        n_err++;
        $display("[TB] FAIL bp_hold[%0d] got v=%b r=%h tag=%0d fx=%h rdy=%b want 1 4400 3 4200 0000",
                 c, rsp_valid, rsp_result, rsp_tag, fma_x, req_ready);
      end
      tick();
    end
    req_valid = '0; rsp_ready = 1'b1;
    #1;
    n_vec++; if (rsp_result !== 16'h4400) begin n_err++; $display("[TB] FAIL bp_release_a got %h want 4400", rsp_result); end
    tick();
    #1;
    n_vec++; if (rsp_valid !== 1'b1 || rsp_result !== 16'h4600 || rsp_tag !== 3'd4 || rsp_id !== 2'd0)
      begin n_err++; $display("[TB] FAIL bp_release_b got v=%b r=%h tag=%0d id=%0d want 1 4600 4 0", rsp_valid, rsp_result, rsp_tag, rsp_id); end
    tick();
    #1;
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("[TB] FAIL bp_drain got v=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_flags;
    bit seen;
    rsp_ready = 1'b1; clr_flags = 1'b0;
    send_op(0, 16'h7BFF, 16'h7BFF, 16'h0000, MUL, 3'd1, seen);
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("[TB] FAIL flags_timeout_1 got no response want response"); end
    n_vec++; if (rsp_result !== 16'h7C00 || rsp_flags !== 4'b0101)
      begin n_err++; $display("[TB] FAIL flags_of_rsp got r=%h f=%b want 7c00 0101", rsp_result, rsp_flags); end
    tick(); #1;
    n_vec++; if (acc_flags !== 4'b0101) begin n_err++; $display("[TB] FAIL flags_acc_1 got %b want 0101", acc_flags); end
    send_op(1, 16'h3C00, 16'h3C00, 16'h0000, MUL, 3'd2, seen);
    n_vec++; if (seen !== 1'b1 || rsp_flags !== 4'b0000 || rsp_id !== 2'd1)
      begin n_err++; $display("[TB] FAIL flags_clean_rsp got seen=%b f=%b id=%0d want 1 0000 1", seen, rsp_flags, rsp_id); end
    tick(); #1;
    n_vec++; if (acc_flags !== 4'b0101) begin n_err++; $display("[TB] FAIL flags_acc_sticky got %b want 0101", acc_flags); end
    send_op(0, 16'h3C00, 16'h3C00, 16'h0C00, FMA, 3'd3, seen);
    n_vec++; if (seen !== 1'b1 || rsp_flags !== 4'b0001)
      begin n_err++; $display("[TB] FAIL flags_nx_rsp got seen=%b f=%b want 1 0001", seen, rsp_flags); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    #1;
    n_vec++; if (acc_flags !== 4'b0001) begin n_err++; $display("[TB] FAIL flags_clr_with_rsp got %b want 0001", acc_flags); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    #1;
    n_vec++; if (acc_flags !== 4'b0000) begin n_err++; $display("[TB] FAIL flags_clr_alone got %b want 0000", acc_flags); end
    send_op(2, 16'h7BFF, 16'h7BFF, 16'h0000, MUL, 3'd4, seen);
    tick(); #1;
    n_vec++; if (seen !== 1'b1 || acc_flags !== 4'b0101)
      begin n_err++; $display("[TB] FAIL flags_acc_final got seen=%b acc=%b want 1 0101", seen, acc_flags); end
  endtask

  task automatic test_reset_midop;
    rsp_ready = 1'b0;
    set_op(0, 16'h4000, 16'h4000, 16'h0000, MUL, 3'd3);
    req_valid = 4'b0001;
    tick();
    set_op(0, 16'h4200, 16'h4000, 16'h0000, MUL, 3'd4);
    tick();
    req_valid = '0;
    #1;
    n_vec++; if (busy !== 1'b1 || rsp_valid !== 1'b1 || fma_x !== 16'h4200)
      begin n_err++; $display("[TB] FAIL midop_full got busy=%b v=%b fx=%h want 1 1 4200", busy, rsp_valid, fma_x); end
    reset = 1'b1;
    #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL midop_rsp_valid got %b want 0", rsp_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL midop_busy got %b want 0", busy); end
    n_vec++; if (acc_flags !== 4'b0000) begin n_err++; $display("[TB] FAIL midop_acc got %b want 0000", acc_flags); end
    n_vec++; if (fma_x !== 16'h0000 || rsp_result !== 16'h0000 || rsp_tag !== 3'd0)
      begin n_err++; $display("[TB] FAIL midop_data got fx=%h r=%h tag=%0d want 0000 0000 0", fma_x, rsp_result, rsp_tag); end
    tick();
    reset = 1'b0; rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL midop_ghost[%0d] got %b want 0", c, rsp_valid); end
      tick();
    end
    set_op(0, 16'h3C00, 16'h4000, 16'h0000, MUL, 3'd5);
    set_op(1, 16'h3C00, 16'h4000, 16'h0000, MUL, 3'd6);
    req_valid = 4'b0011;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("[TB] FAIL midop_first_grant got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    repeat (2) tick();
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL midop_drain got busy=%b want 0", busy); end
  endtask

  task automatic test_wrap_sparse;
    logic [3:0] exp_ready;
    rsp_ready = 1'b1;
    set_op(3, 16'h3C00, 16'h4000, 16'h0000, MUL, 3'd7);
    req_valid = 4'b1000;
    #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("[TB] FAIL wrap_seed got %b want 1000", req_ready); end
    tick();
    req_valid = '0;
    repeat (2) tick();
    set_op(1, 16'h3C00, 16'h4000, 16'h0000, MUL, 3'd1);
    set_op(3, 16'h3C00, 16'h4000, 16'h0000, MUL, 3'd3);
    req_valid = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      #1;
      exp_ready = ((c % 2) != 0) ? 4'b1000 : 4'b0010;
      n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("[TB] FAIL wrap_ready[%0d] got %b want %b", c, req_ready, exp_ready); end
      if (c >= 2) begin
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((c % 2) != 0 ? 3 : 1))
          begin n_err++; $display("[TB] FAIL wrap_id[%0d] got v=%b id=%0d want 1 %0d", c, rsp_valid, rsp_id, (c % 2) != 0 ? 3 : 1); end
      end
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    req_valid = 4'b1010;
    #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("[TB] FAIL wrap_idle_hold got %b want 1000", req_ready); end
    tick();
    req_valid = '0;
    repeat (3) tick();
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL wrap_drain got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_flags();
    test_reset_midop();
    test_wrap_sparse();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
